// File: rtl/mandelbrot_pkg.sv
// Shared fixed-point constants, types and coordinate-generator FSM states
// for the Mandelbrot datapath.
package mandelbrot_pkg;

  localparam int unsigned WIDTH = 27;
  localparam int unsigned FRAC  = 23;

  typedef logic signed [WIDTH-1:0] fx_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } coord_gen_state_t;

endpackage

// File: rtl/mandelbrot_coord_gen.sv
// Raster-scans one frame and streams a complex coordinate per pixel over a
// valid/ready handshake, stepping c_re/c_im by incremental add/subtract.
module mandelbrot_coord_gen #(
  parameter int unsigned WIDTH = mandelbrot_pkg::WIDTH,
  parameter int unsigned H_RES = 640,
  parameter int unsigned V_RES = 480
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     start,
  input  logic [WIDTH-1:0]         x0,
  input  logic [WIDTH-1:0]         y0,
  input  logic [WIDTH-1:0]         dx,
  input  logic [WIDTH-1:0]         dy,
  output logic                     coord_valid,
  input  logic                     coord_ready,
  output logic [$clog2(H_RES)-1:0] pix_x,
  output logic [$clog2(V_RES)-1:0] pix_y,
  output logic [WIDTH-1:0]         c_re,
  output logic [WIDTH-1:0]         c_im,
  output logic                     busy,
  output logic                     done
);
  import mandelbrot_pkg::*;

  localparam int unsigned XW = $clog2(H_RES);
  localparam int unsigned YW = $clog2(V_RES);

  coord_gen_state_t state, state_d;

  logic [WIDTH-1:0] x0_q, dx_q, dy_q;
  logic             capture;

  logic             valid_d, busy_d, done_d;
  logic [XW-1:0]    pix_x_d;
  logic [YW-1:0]    pix_y_d;
  logic [WIDTH-1:0] c_re_d, c_im_d;

  logic last_col, last_row;
  assign last_col = (pix_x == XW'(H_RES - 1));
  assign last_row = (pix_y == YW'(V_RES - 1));

  // Next-state and next-output logic; outputs hold unless explicitly changed.
  always_comb begin
    state_d = state;
    valid_d = coord_valid;
    pix_x_d = pix_x;
    pix_y_d = pix_y;
    c_re_d  = c_re;
    c_im_d  = c_im;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    capture = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          capture = 1'b1;
          valid_d = 1'b1;
          busy_d  = 1'b1;
          pix_x_d = '0;
          pix_y_d = '0;
          c_re_d  = x0;
          c_im_d  = y0;
        end
      end
      RUN: begin
        busy_d = 1'b1;
        if (coord_valid && coord_ready) begin
          if (!last_col) begin
            pix_x_d = pix_x + XW'(1);
            c_re_d  = c_re + dx_q;
          end else if (!last_row) begin
            pix_x_d = '0;
            c_re_d  = x0_q;
            pix_y_d = pix_y + YW'(1);
            c_im_d  = c_im - dy_q;
          end else begin
            state_d = DONE;
            valid_d = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      coord_valid <= 1'b0;
      pix_x       <= '0;
      pix_y       <= '0;
      c_re        <= '0;
      c_im        <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      state       <= state_d;
      coord_valid <= valid_d;
      pix_x       <= pix_x_d;
      pix_y       <= pix_y_d;
      c_re        <= c_re_d;
      c_im        <= c_im_d;
      busy        <= busy_d;
      done        <= done_d;
    end
  end

  // Frame parameters are frozen at start so mid-frame PIO writes are invisible.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      x0_q <= '0;
      dx_q <= '0;
      dy_q <= '0;
    end else if (capture) begin
      x0_q <= x0;
      dx_q <= dx;
      dy_q <= dy;
    end
  end

endmodule

// File: tb/tb_mandelbrot_coord_gen.sv
// Scoreboard bench for mandelbrot_coord_gen on a 4x3 frame in 4.23 fixed point.
module tb_mandelbrot_coord_gen;

  localparam int unsigned W  = 27;
  localparam int unsigned HR = 4;
  localparam int unsigned VR = 3;

  typedef struct packed {
    logic [1:0]   px;
    logic [1:0]   py;
    logic [W-1:0] re;
    logic [W-1:0] im;
  } exp_t;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         start;
  logic [W-1:0] x0, y0, dx, dy;
  logic         coord_valid, coord_ready;
  logic [1:0]   pix_x, pix_y;
  logic [W-1:0] c_re, c_im;
  logic         busy, done;

  always #5 clk = ~clk;

  mandelbrot_coord_gen #(.WIDTH(W), .H_RES(HR), .V_RES(VR)) dut (
    .clk(clk), .reset_n(reset_n), .start(start),
    .x0(x0), .y0(y0), .dx(dx), .dy(dy),
    .coord_valid(coord_valid), .coord_ready(coord_ready),
    .pix_x(pix_x), .pix_y(pix_y), .c_re(c_re), .c_im(c_im),
    .busy(busy), .done(done)
  );

  exp_t        exp_q[$];
  int          tests = 0;
  int          fails = 0;
  int          cyc = 0;
  int          done_cnt = 0, done_cyc = 0;
  int          xfer_cnt = 0, first_xfer = -1, last_xfer = -1;
  bit          hold_pending = 1'b0;
  logic [63:0] snap;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  function automatic logic [63:0] out_vec();
    return 64'({coord_valid, pix_x, pix_y, c_re, c_im});
  endfunction

  // Reference frame: pixel (c,r) = (x0 + c*dx, y0 - r*dy), wrapping at W bits.
  task automatic push_frame(input logic [W-1:0] x0v, y0v, dxv, dyv);
    exp_t e;
    for (int r = 0; r < int'(VR); r++)
      for (int c = 0; c < int'(HR); c++) begin
        e.px = 2'(c);
        e.py = 2'(r);
        e.re = W'(x0v + W'(c) * dxv);
        e.im = W'(y0v - W'(r) * dyv);
        exp_q.push_back(e);
      end
  endtask

  task automatic reset_stats();
    done_cnt = 0; xfer_cnt = 0; first_xfer = -1; last_xfer = -1; done_cyc = 0;
  endtask

  // One clock: drive inputs and check outputs at the falling edge.
  task automatic tick(input bit rdy, input bit st);
    exp_t e;
    @(negedge clk);
    cyc++;
    if (hold_pending) begin
      check("hold_stable", out_vec(), snap);
      hold_pending = 1'b0;
    end
    start       = st;
    coord_ready = rdy;
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (coord_valid) begin
      check("busy_in_run", 64'(busy), 64'(1));
      if (rdy) begin
        if (exp_q.size() == 0) begin
          check("unexpected_xfer", 64'(exp_q.size()), 64'(1));
        end else begin
          e = exp_q.pop_front();
          check($sformatf("coord_%0d_%0d", e.px, e.py),
                64'({pix_x, pix_y, c_re, c_im}), 64'(e));
        end
        xfer_cnt++;
        if (first_xfer < 0) first_xfer = cyc;
        last_xfer = cyc;
      end else begin
        snap = out_vec();
        hold_pending = 1'b1;
      end
    end
  endtask

  task automatic wait_done(input int budget, input bit rnd);
    int n = 0;
    int d0 = done_cnt;
    while (done_cnt == d0 && n < budget) begin
      tick(rnd ? 1'($urandom_range(0, 1)) : 1'b1, 1'b0);
      n++;
    end
    check("done_seen", 64'(done_cnt - d0), 64'(1));
    tick(1'b1, 1'b0);
    check("idle_after_done", 64'({busy, done, coord_valid}), 64'(0));
  endtask

  int start_cyc;

  initial begin
    reset_n = 1'b0; start = 1'b0; coord_ready = 1'b0;
    x0 = 27'h7000000; y0 = 27'h0800000; dx = 27'h0400000; dy = 27'h0200000;
    #12;
    check("reset_outputs", 64'({coord_valid, pix_x, pix_y, c_re, c_im, busy, done}), 64'(0));
    @(negedge clk);
    reset_n = 1'b1;

    // Mid-frame asynchronous reset
    push_frame(x0, y0, dx, dy);
    tick(1'b1, 1'b1);
    for (int i = 0; i < 5; i++) tick(1'b1, 1'b0);
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1 check("async_reset", 64'({coord_valid, pix_x, pix_y, c_re, c_im, busy, done}), 64'(0));
    @(negedge clk);
    reset_n = 1'b1;
    exp_q.delete();
    hold_pending = 1'b0;
    for (int i = 0; i < 3; i++) tick(1'b1, 1'b0);
    check("idle_after_reset", 64'({coord_valid, busy, done}), 64'(0));

    // Full frame, ready held high
    reset_stats();
    push_frame(x0, y0, dx, dy);
    tick(1'b1, 1'b1);
    start_cyc = cyc;
    wait_done(40, 1'b0);
    check("xfer_count", 64'(xfer_cnt), 64'(12));
    check("start_latency", 64'(first_xfer), 64'(start_cyc + 1));
    check("consecutive", 64'(last_xfer - first_xfer), 64'(11));
    check("done_timing", 64'(done_cyc), 64'(last_xfer + 1));
    check("done_once", 64'(done_cnt), 64'(1));
    check("queue_empty_a", 64'(exp_q.size()), 64'(0));

    // Random backpressure
    reset_stats();
    push_frame(x0, y0, dx, dy);
    tick(1'b1, 1'b1);
    wait_done(300, 1'b1);
    check("xfer_count_rnd", 64'(xfer_cnt), 64'(12));
    check("queue_empty_b", 64'(exp_q.size()), 64'(0));

    // PIO write and start pulse mid-frame are ignored
    reset_stats();
    push_frame(x0, y0, dx, dy);
    tick(1'b1, 1'b1);
    tick(1'b1, 1'b0);
    tick(1'b1, 1'b0);
    dx = 27'h0100000;
    x0 = 27'h0000000;
    tick(1'b1, 1'b1);
    wait_done(40, 1'b0);
    check("xfer_count_mid", 64'(xfer_cnt), 64'(12));
    check("queue_empty_c", 64'(exp_q.size()), 64'(0));

    // Near +max x0: c_re wraps negative without stalling
    reset_stats();
    x0 = 27'h3F33333; dx = 27'h0400000;
    push_frame(x0, y0, dx, dy);
    tick(1'b1, 1'b1);
    start_cyc = cyc;
    wait_done(40, 1'b0);
    check("wrap_consecutive", 64'(last_xfer - first_xfer), 64'(11));
    check("queue_empty_d", 64'(exp_q.size()), 64'(0));

    // start held high: back-to-back frames
    reset_stats();
    x0 = 27'h7000000; dx = 27'h0400000;
    push_frame(x0, y0, dx, dy);
    push_frame(x0, y0, dx, dy);
    begin
      int n = 0;
      while (done_cnt < 2 && n < 80) begin
        tick(1'b1, 1'b1);
        n++;
      end
    end
    for (int i = 0; i < 3; i++) tick(1'b1, 1'b0);
    check("b2b_done_count", 64'(done_cnt), 64'(2));
    check("b2b_xfer_count", 64'(xfer_cnt), 64'(24));
    check("queue_empty_e", 64'(exp_q.size()), 64'(0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
